register_file: RTL and testbench
================================

Name: register_file

Overview:
- Integer register file for the single-cycle RV32I core.
- Sits directly upstream of the ALU and drives both of its operand buses (op1 via rs1Data, op2 via rs2Data through the immediate mux).
- Accepts the writeback result (ALU result, load data or PC+4) on the rising clock edge.
- A post-reset scrub state machine zeroes every register. It holds `ready` low until the scrub completes, and the core stalls the PC on that signal.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; x0 is included but never stored.
- AW, 5, address width; must equal $clog2(NREGS).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rs1Addr  input  AW  read port 1 address.
- rs2Addr  input  AW  read port 2 address.
- rdAddr  input  AW  write port address.
- we  input  1  write enable, qualified by `ready`.
- wdata  input  XLEN  write data.
- rs1Data  output  XLEN  read port 1 data; feeds ALU op1.
- rs2Data  output  XLEN  read port 2 data; feeds the ALU op2 mux and store data.
- ready  output  1  high once the scrub is done; core advances the PC only when high.

Interface note (already decided):
- One clock, clk.
- Reset is synchronous and active-high, port name reset.

Behaviour:
- Storage: NREGS-1 entries of XLEN bits, indices 1..NREGS-1. Index 0 has no storage.
- Reads:
  - Combinational and asynchronous from the address inputs, zero-cycle latency.
  - Address 0 always returns 0.
  - While `ready`=0, both read ports return 0 regardless of address.
- Writes:
  - Take effect on the rising clk edge when we=1, ready=1 and rdAddr!=0.
  - Write to rdAddr=0 is silently dropped.
  - we while ready=0 is dropped; no queuing.
- FSM states:
  - SCRUB: a scrub counter `scrubIdx` (AW bits) writes 0 to entry scrubIdx each cycle.
  - RUN: normal operation.
- Reset:
  - Any cycle with reset=1 forces state to SCRUB, sets scrubIdx to 1 and drives ready=0.
  - Storage contents are not cleared by reset itself; the scrub clears them.
- SCRUB transitions:
  - Each non-reset cycle writes entry scrubIdx to 0 and increments scrubIdx.
  - When scrubIdx==NREGS-1 is written, next state is RUN.
  - SCRUB therefore lasts NREGS-1 cycles after reset deasserts (31 at default).
  - ready rises on the first cycle in RUN and is a registered output.
- RUN: stays in RUN until reset; ready=1.
- Reset mid-scrub: restarts from scrubIdx=1. Reset during RUN: re-enters SCRUB, and the full scrub repeats.
- Same-cycle write and read of the same address (RUN, macro absent): the read returns the old value; the new value is visible from the next cycle.
- Both read ports may address the same register simultaneously. Both return identical data.
- No X propagation: every output is defined in every state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a write-through bypass is compiled in. When we=1, ready=1, rdAddr!=0 and rdAddr equals rs1Addr (or rs2Addr), that port returns wdata combinationally in the same cycle. x0 and the SCRUB zeroing still take priority.
- Undefined: no bypass logic; same-cycle read returns the stored value.
- Purpose: used when the team later pipelines the core, so that writeback-to-decode forwarding is absorbed here.

Decomposition:
- Shared package `riscv_pkg` holds:
  - XLEN and register-address width constants.
  - Register index constants (REG_ZERO=0, REG_RA=1, REG_SP=2).
  - The FSM state enum rf_state_t {RF_SCRUB, RF_RUN}.
- One sub-module is natural: `regfile_read_port`, instantiated twice. It contains the address mux, the x0/not-ready zero forcing and the optional bypass compare.

Test Plan:
- Reset timing: assert reset for 3 cycles, then release. Required: ready=0 for exactly 31 cycles after release, ready=1 on cycle 32. rs1Data=rs2Data=0 throughout, for any address.
- Basic write/read and x0: in RUN, write 0xDEADBEEF to x5, then read rs1Addr=5, rs2Addr=5. Required: both ports show 0xDEADBEEF next cycle. Write 0x12345678 to x0; required: rs1Addr=0 reads 0.
- Same-cycle write/read: write 0xA5A5A5A5 to x7 while rs1Addr=7 in the same cycle (old value 0x1). Required: rs1Data=0x1 without REGFILE_BYPASS_EN, 0xA5A5A5A5 with it; 0xA5A5A5A5 next cycle in both builds.
- Dropped writes: pulse reset, then issue we=1, rdAddr=3, wdata=0xFFFFFFFF during SCRUB. Required: x3 reads 0 after ready rises.
- Reset mid-scrub: assert reset at scrub cycle 10, release. Required: full 31-cycle scrub restarts and ready rises 31 cycles after the second release.
- Reset during RUN: fill x1..x31 with their index values, assert reset 1 cycle. Required: after the scrub, all registers read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants, register indices and register-file FSM states
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_RA   = 5'd1;
    localparam logic [REG_AW-1:0] REG_SP   = 5'd2;

    typedef enum logic {
        RF_SCRUB = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port: address mux, x0/not-ready zeroing, optional REGFILE_BYPASS_EN write-through
module regfile_read_port #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS,
    parameter int AW    = riscv_pkg::REG_AW
) (
    input  logic                       i_ready,
    input  logic [AW-1:0]              i_addr,
    input  logic [NREGS-1:1][XLEN-1:0] i_regs,
`ifdef REGFILE_BYPASS_EN
    input  logic                       i_we,
    input  logic [AW-1:0]              i_wr_addr,
    input  logic [XLEN-1:0]            i_wdata,
`endif
    output logic [XLEN-1:0]            o_data
);
    import riscv_pkg::*;

    logic [XLEN-1:0] w_stored;

    // Select the stored entry; address 0 matches no entry and yields zero.
    always_comb begin
        w_stored = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (i_addr == AW'(i)) begin
                w_stored = i_regs[i];
            end
        end
    end

    // Zero while scrubbing or for x0; otherwise stored data, optionally overridden by the in-flight write.
    always_comb begin
        o_data = '0;
        if (i_ready && (i_addr != '0)) begin
            o_data = w_stored;
`ifdef REGFILE_BYPASS_EN
            if (i_we && (i_wr_addr != '0) && (i_wr_addr == i_addr)) begin
                o_data = i_wdata;
            end
`endif
        end
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - RV32I integer register file with post-reset scrub; optional REGFILE_BYPASS_EN write-through
module register_file #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS,
    parameter int AW    = riscv_pkg::REG_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1Addr,
    input  logic [AW-1:0]   rs2Addr,
    input  logic [AW-1:0]   rdAddr,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rs1Data,
    output logic [XLEN-1:0] rs2Data,
    output logic            ready
);
    import riscv_pkg::*;

    rf_state_t                  r_state;
    rf_state_t                  w_state_next;
    logic [AW-1:0]              r_scrub_idx;
    logic [AW-1:0]              w_scrub_idx_next;
    logic                       w_scrub_wr;
    logic                       w_wr_en;
    logic                       r_ready;
    logic [NREGS-1:1][XLEN-1:0] r_regs;

    // Next-state logic: walk scrubIdx through 1..NREGS-1, then settle in RUN.
    always_comb begin
        w_state_next     = r_state;
        w_scrub_idx_next = r_scrub_idx;
        w_scrub_wr       = 1'b0;
        case (r_state)
            RF_SCRUB: begin
                w_scrub_wr       = 1'b1;
                w_scrub_idx_next = r_scrub_idx + AW'(1);
                if (r_scrub_idx == AW'(NREGS - 1)) begin
                    w_state_next = RF_RUN;
                end
            end
            RF_RUN: begin
                w_state_next = RF_RUN;
            end
            default: begin
                w_state_next = RF_SCRUB;
            end
        endcase
    end

    // State, scrub counter and registered ready; reset restarts the scrub from entry 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RF_SCRUB;
            r_scrub_idx <= AW'(1);
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_scrub_idx <= w_scrub_idx_next;
            r_ready     <= (w_state_next == RF_RUN);
        end
    end

    assign w_wr_en = r_ready && we && (rdAddr != '0);

    // Storage is not reset; the scrub zeroes it, and architectural writes only land once ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_scrub_wr) begin
                r_regs[r_scrub_idx] <= '0;
            end else if (w_wr_en) begin
                r_regs[rdAddr] <= wdata;
            end
        end
    end

    assign ready = r_ready;

    regfile_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rd_port1 (
        .i_ready   (r_ready),
        .i_addr    (rs1Addr),
        .i_regs    (r_regs),
`ifdef REGFILE_BYPASS_EN
        .i_we      (we),
        .i_wr_addr (rdAddr),
        .i_wdata   (wdata),
`endif
        .o_data    (rs1Data)
    );

    regfile_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rd_port2 (
        .i_ready   (r_ready),
        .i_addr    (rs2Addr),
        .i_regs    (r_regs),
`ifdef REGFILE_BYPASS_EN
        .i_we      (we),
        .i_wr_addr (rdAddr),
        .i_wdata   (wdata),
`endif
        .o_data    (rs2Data)
    );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard testbench for register_file
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1Addr, rs2Addr, rdAddr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rs1Data, rs2Data;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        rdy;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_mem [32];
    logic        m_ready;
    int          m_left;

    always #5 clk = ~clk;

    register_file dut (
        .clk     (clk),
        .reset   (reset),
        .rs1Addr (rs1Addr),
        .rs2Addr (rs2Addr),
        .rdAddr  (rdAddr),
        .we      (we),
        .wdata   (wdata),
        .rs1Data (rs1Data),
        .rs2Data (rs2Data),
        .ready   (ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] addr, input logic w,
                                           input logic [4:0] rd, input logic [31:0] wd);
        if (!m_ready || addr == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (w && rd != 5'd0 && rd == addr) return wd;
`endif
        return m_mem[addr];
    endfunction

    task automatic run_cycle(input logic rst, input logic w, input logic [4:0] rd,
                             input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                             output logic rdy_obs);
        exp_t e;
        exp_t g;
        reset   = rst;
        we      = w;
        rdAddr  = rd;
        wdata   = wd;
        rs1Addr = a1;
        rs2Addr = a2;
        e.d1  = m_read(a1, w, rd, wd);
        e.d2  = m_read(a2, w, rd, wd);
        e.rdy = m_ready;
        sb_q.push_back(e);
        #3;
        g = sb_q.pop_front();
        check("rs1Data", rs1Data, g.d1);
        check("rs2Data", rs2Data, g.d2);
        check("ready", {31'b0, ready}, {31'b0, g.rdy});
        rdy_obs = ready;
        @(posedge clk);
        if (rst) begin
            m_ready = 1'b0;
            m_left  = 31;
        end else if (!m_ready) begin
            m_mem[32 - m_left] = 32'h0;
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end else if (w && rd != 5'd0) begin
            m_mem[rd] = wd;
        end
        #1;
    endtask

    task automatic wait_ready(input string tag, input logic wr3);
        logic r;
        int   lows;
        lows = 0;
        for (int k = 0; k < 40; k++) begin
            run_cycle(1'b0, wr3, 5'd3, 32'hFFFF_FFFF, 5'($urandom), 5'($urandom), r);
            if (r) break;
            lows++;
        end
        check(tag, lows, 32'd31);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic r;
        reset   = 1'b1;
        we      = 1'b0;
        rdAddr  = '0;
        wdata   = '0;
        rs1Addr = '0;
        rs2Addr = '0;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        m_ready = 1'b0;
        m_left  = 31;

        // reset timing
        wait_ready("scrub_len", 1'b0);

        // basic write/read and x0
        run_cycle(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, r);
        run_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, r);
        check("x5_rs1", rs1Data, 32'hDEAD_BEEF);
        run_cycle(1'b0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd5, r);
        run_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, r);

        // same-cycle write and read
        run_cycle(1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0, r);
        run_cycle(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7, r);
        run_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, r);

        // random traffic in RUN
        for (int i = 0; i < 40; i++) begin
            run_cycle(1'b0, 1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom), r);
        end

        // writes during scrub are dropped
        run_cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, r);
        wait_ready("scrub_drop", 1'b1);
        run_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, r);

        // reset in the middle of the scrub
        run_cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, r);
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'($urandom), 5'($urandom), r);
        end
        run_cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, r);
        wait_ready("scrub_restart", 1'b0);

        // fill, reset during RUN, confirm everything is scrubbed
        for (int i = 1; i < 32; i++) begin
            run_cycle(1'b0, 1'b1, 5'(i), 32'(i), 5'(i - 1), 5'(i), r);
        end
        for (int i = 0; i < 32; i++) begin
            run_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), r);
        end
        run_cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, r);
        wait_ready("scrub_run_reset", 1'b0);
        for (int i = 0; i < 32; i++) begin
            run_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), r);
            check("post_scrub_zero", rs1Data, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
